sample_avg_dec: RTL and testbench

//  Accumulate-and-dump decimator that consumes the 16-bit sample stream leaving the
//  N-stage pipeline delay line of the ADC acquisition path. Sums 2^LOG2_N accepted

---
 rtl/ecs_pkg.sv | 7 +
 rtl/sample_avg_acc.sv | 56 +++++
 rtl/sample_avg_dec.sv | 84 ++++++++
 tb/tb_sample_avg_dec.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ecs_pkg.sv
// Constants shared by the acquisition path: delay line, decimator and result formatter.
package ecs_pkg;

    localparam int unsigned SAMPLE_W   = 16;
    localparam int unsigned DEC_LOG2_N = 3;

endpackage

// File: rtl/sample_avg_acc.sv
// Block accumulator for the decimator: running sum, sample counter and block-end strobe.
module sample_avg_acc
    import ecs_pkg::*;
#(
    parameter int unsigned WIDTH  = SAMPLE_W,
    parameter int unsigned LOG2_N = DEC_LOG2_N
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          d,
    output logic                      blk_end,
    output logic [WIDTH+LOG2_N-1:0]   blk_sum
);

    localparam int unsigned AW = WIDTH + LOG2_N;
    localparam logic [LOG2_N-1:0] CNT_LAST = '1;

    logic [AW-1:0]     acc_q, acc_d;
    logic [AW-1:0]     d_ext;
    logic [AW-1:0]     acc_sum;
    logic [LOG2_N-1:0] cnt_q, cnt_d;
    logic              accept;

    always_comb begin
        d_ext   = {{LOG2_N{d[WIDTH-1]}}, d};
        acc_sum = acc_q + d_ext;
        accept  = in_valid & ~clr;
        blk_end = accept && (cnt_q == CNT_LAST);

        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clr || blk_end) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            acc_d = acc_sum;
            cnt_d = cnt_q + LOG2_N'(1);
        end
    end

    // The block-end sum includes the sample being accepted this cycle.
    assign blk_sum = acc_sum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sample_avg_dec.sv
// Accumulate-and-dump decimator: mean and full sum of 2^LOG2_N samples, valid/ready output, sticky overrun.
module sample_avg_dec
    import ecs_pkg::*;
#(
    parameter int unsigned WIDTH  = SAMPLE_W,
    parameter int unsigned LOG2_N = DEC_LOG2_N
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          d,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          q,
    output logic [WIDTH+LOG2_N-1:0]   sum,
    output logic                      overrun
);

    localparam int unsigned AW = WIDTH + LOG2_N;

    logic          blk_end;
    logic [AW-1:0] blk_sum;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [AW-1:0]    sum_q, sum_d;
    logic             overrun_q, overrun_d;

    sample_avg_acc #(
        .WIDTH  (WIDTH),
        .LOG2_N (LOG2_N)
    ) u_acc (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_valid (in_valid),
        .d        (d),
        .blk_end  (blk_end),
        .blk_sum  (blk_sum)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        q_d         = q_q;
        sum_d       = sum_q;
        overrun_d   = overrun_q;

        if (clr) begin
            out_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end else if (blk_end) begin
            sum_d       = blk_sum;
            // Upper WIDTH bits of the sum equal sum >>> LOG2_N (floor toward -inf).
            q_d         = blk_sum[AW-1:LOG2_N];
            out_valid_d = 1'b1;
            if (out_valid_q && !out_ready) begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            q_q         <= '0;
            sum_q       <= '0;
            overrun_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            q_q         <= q_d;
            sum_q       <= sum_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_valid = out_valid_q;
    assign q         = q_q;
    assign sum       = sum_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sample_avg_dec.sv
// Self-checking bench for sample_avg_dec: directed block table, handshake/reset corners, random traffic vs model.
module tb_sample_avg_dec;

    localparam int W = 16;
    localparam int L = 3;
    localparam int N = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             clr = 1'b0;
    logic             in_valid = 1'b0;
    logic [W-1:0]     d = '0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [W-1:0]     q;
    logic [W+L-1:0]   sum;
    logic             overrun;

    int checks = 0;
    int errors = 0;

    sample_avg_dec #(
        .WIDTH  (W),
        .LOG2_N (L)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .d         (d),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .q         (q),
        .sum       (sum),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Reference model: list of accepted samples of the open block plus the result register.
    int m_samples[$];
    bit m_valid;
    bit m_ovr;
    int m_sum;
    int m_q;

    function automatic int floor_div_n(int s);
        int r;
        r = s % N;
        if (r < 0) r += N;
        return (s - r) / N;
    endfunction

    function automatic void model_reset();
        m_samples.delete();
        m_valid = 0;
        m_ovr   = 0;
        m_sum   = 0;
        m_q     = 0;
    endfunction

    function automatic void model_step(bit c, bit iv, int dv, bit rdy);
        int total;
        bit done;
        if (c) begin
            m_samples.delete();
            m_valid = 0;
            m_ovr   = 0;
            return;
        end
        done = 0;
        if (iv) begin
            m_samples.push_back(dv);
            if (m_samples.size() == N) begin
                total = 0;
                foreach (m_samples[i]) total += m_samples[i];
                m_samples.delete();
                done = 1;
            end
        end
        if (done) begin
            if (m_valid && !rdy) m_ovr = 1;
            m_valid = 1;
            m_sum   = total;
            m_q     = floor_div_n(total);
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".out_valid"}, int'(out_valid), int'(m_valid));
        check({tag, ".overrun"},   int'(overrun),   int'(m_ovr));
        check({tag, ".sum"},       int'($signed(sum)), m_sum);
        check({tag, ".q"},         int'($signed(q)),   m_q);
    endtask

    // Drive one cycle of inputs, clock it, then compare 1 time unit after the edge.
    task automatic apply(input bit c, input bit iv, input int dv, input bit rdy, input string tag);
        logic [31:0] dbits;
        dbits     = dv;
        clr       = c;
        in_valid  = iv;
        d         = dbits[W-1:0];
        out_ready = rdy;
        @(posedge clk);
        model_step(c, iv, dv, rdy);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset(input string tag);
        clr = 0; in_valid = 0; out_ready = 0;
        rst = 0;
        #2;
        model_reset();
        compare_all({tag, ".async"});
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    typedef struct {
        int d[N];
        int exp_sum;
        int exp_q;
    } blk_vec_t;

    blk_vec_t tbl[6];

    initial begin
        for (int i = 0; i < 6; i++)
            for (int k = 0; k < N; k++) tbl[i].d[k] = 0;
        for (int k = 0; k < N; k++) begin
            tbl[0].d[k] = 100;
            tbl[1].d[k] = -3;
            tbl[4].d[k] = 32767;
            tbl[5].d[k] = -32768;
        end
        tbl[2].d[0] = -1;
        tbl[3].d[0] = 1;
        tbl[0].exp_sum = 800;     tbl[0].exp_q = 100;
        tbl[1].exp_sum = -24;     tbl[1].exp_q = -3;
        tbl[2].exp_sum = -1;      tbl[2].exp_q = -1;
        tbl[3].exp_sum = 1;       tbl[3].exp_q = 0;
        tbl[4].exp_sum = 262136;  tbl[4].exp_q = 32767;
        tbl[5].exp_sum = -262144; tbl[5].exp_q = -32768;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        rst = 1;

        // Directed blocks: result appears the edge after the 8th sample, then drains.
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < N - 1; k++) apply(0, 1, tbl[i].d[k], 1, "tbl_fill");
            check("tbl_pre_valid", int'(out_valid), 0);
            apply(0, 1, tbl[i].d[N-1], 1, "tbl_end");
            check("tbl_sum", int'($signed(sum)), tbl[i].exp_sum);
            check("tbl_q",   int'($signed(q)),   tbl[i].exp_q);
            check("tbl_valid", int'(out_valid), 1);
            apply(0, 0, 0, 1, "tbl_drain");
            check("tbl_pulse", int'(out_valid), 0);
        end

        // Two blocks with no consumer: second overwrites first, overrun sticks until clr.
        for (int k = 0; k < N; k++) apply(0, 1, 10, 0, "ovr_b1");
        apply(0, 0, 0, 0, "ovr_gap");
        for (int k = 0; k < N; k++) apply(0, 1, 20, 0, "ovr_b2");
        check("ovr_q", int'($signed(q)), 20);
        check("ovr_flag", int'(overrun), 1);
        check("ovr_valid", int'(out_valid), 1);
        apply(1, 0, 0, 1, "ovr_clr");
        check("clr_valid", int'(out_valid), 0);
        check("clr_ovr", int'(overrun), 0);
        check("clr_q_kept", int'($signed(q)), 20);

        // Consumer ready exactly on the second block end: no bubble, no overrun.
        for (int k = 0; k < N; k++) apply(0, 1, 30, 0, "hs_b1");
        for (int k = 0; k < N - 1; k++) apply(0, 1, 40, 0, "hs_b2");
        apply(0, 1, 40, 1, "hs_end");
        check("hs_valid", int'(out_valid), 1);
        check("hs_ovr", int'(overrun), 0);
        check("hs_sum", int'($signed(sum)), 320);
        apply(0, 0, 0, 1, "hs_drain");

        // Reset mid-block drops the partial sum.
        for (int k = 0; k < 5; k++) apply(0, 1, 9, 1, "rst_part");
        do_reset("rst_mid");
        for (int k = 0; k < N; k++) apply(0, 1, 7, 1, "rst_blk");
        check("rst_sum", int'($signed(sum)), 56);
        check("rst_q", int'($signed(q)), 7);

        // clr with in_valid discards that sample along with the partial block.
        for (int k = 0; k < 5; k++) apply(0, 1, 9, 1, "clr_part");
        apply(1, 1, 1000, 1, "clr_iv");
        for (int k = 0; k < N; k++) apply(0, 1, 7, 1, "clr_blk");
        check("clr_sum", int'($signed(sum)), 56);
        check("clr_q", int'($signed(q)), 7);

        // Random traffic with gaps, back-pressure, clr and occasional reset.
        for (int n = 0; n < 3000; n++) begin
            bit c, iv, rdy;
            int dv;
            if ($urandom_range(0, 499) == 0) begin
                do_reset("rnd_rst");
            end else begin
                c   = ($urandom_range(0, 39) == 0);
                iv  = ($urandom_range(0, 9) < 7);
                rdy = ($urandom_range(0, 1) == 1);
                case ($urandom_range(0, 7))
                    0:       dv = 32767;
                    1:       dv = -32768;
                    default: dv = int'($urandom_range(0, 65535)) - 32768;
                endcase
                apply(c, iv, dv, rdy, "rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
